// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - shared widths, defaults and FSM encodings for the hazard/stall controller
package hazard_stall_ctrl_pkg;

  localparam int REGFILE_ADDRESS_LEN = 4;
  localparam int MEM_TIMEOUT_DEFAULT = 64;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - pipeline-side hazard inputs and freeze/flush/bubble strobes
interface hazard_stall_ctrl_if #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
);

  logic                  en_forwarding;
  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;
  logic                  src1_valid;
  logic                  src2_valid;
  logic [REG_ADDR_W-1:0] EXE_dst;
  logic                  EXE_wb_en;
  logic                  EXE_mem_r_en;
  logic [REG_ADDR_W-1:0] MEM_dst;
  logic                  MEM_wb_en;
  logic                  mem_req;
  logic                  mem_ready;
  logic                  branch_taken;

  logic                  hazard;
  logic                  freeze_pc;
  logic                  freeze_if_id;
  logic                  bubble_id_exe;
  logic                  freeze_all;
  logic                  flush_if_id;
  logic                  flush_id_exe;
  logic                  mem_timeout;
  logic [CNT_W-1:0]      stall_count;
  logic [CNT_W-1:0]      bubble_count;

  modport master (
    output en_forwarding, src1, src2, src1_valid, src2_valid,
           EXE_dst, EXE_wb_en, EXE_mem_r_en, MEM_dst, MEM_wb_en,
           mem_req, mem_ready, branch_taken,
    input  hazard, freeze_pc, freeze_if_id, bubble_id_exe, freeze_all,
           flush_if_id, flush_id_exe, mem_timeout, stall_count, bubble_count
  );

  modport slave (
    input  en_forwarding, src1, src2, src1_valid, src2_valid,
           EXE_dst, EXE_wb_en, EXE_mem_r_en, MEM_dst, MEM_wb_en,
           mem_req, mem_ready, branch_taken,
    output hazard, freeze_pc, freeze_if_id, bubble_id_exe, freeze_all,
           flush_if_id, flush_id_exe, mem_timeout, stall_count, bubble_count
  );

endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// rtl/hazard_stall_ctrl_sat_counter.sv - up counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - RAW hazard detect, load-use bubbles, SRAM-wait freeze, branch flush sequencing
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = REGFILE_ADDRESS_LEN,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input logic                clk,
  input logic                rst,
  hazard_stall_ctrl_if.slave bus
);

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_e             state_q;
  logic [WAIT_W-1:0]     wait_cnt_q;
  logic                  mem_timeout_q;

  logic [REG_ADDR_W-1:0] exe_dst;
  logic [REG_ADDR_W-1:0] mem_dst;
  logic                  raw_exe;
  logic                  raw_mem;
  logic                  hazard;
  logic                  freeze_all;

  assign exe_dst = bus.EXE_dst;
  assign mem_dst = bus.MEM_dst;

  assign raw_exe = bus.EXE_wb_en &&
                   ((bus.src1_valid && (bus.src1 == exe_dst)) ||
                    (bus.src2_valid && (bus.src2 == exe_dst)));
  assign raw_mem = bus.MEM_wb_en &&
                   ((bus.src1_valid && (bus.src1 == mem_dst)) ||
                    (bus.src2_valid && (bus.src2 == mem_dst)));

  // With forwarding only a load in EXE cannot be bypassed in time.
  assign hazard = bus.en_forwarding ? (raw_exe && bus.EXE_mem_r_en) : (raw_exe || raw_mem);

  assign freeze_all = (state_q == HZ_RUN) ? (bus.mem_req && !bus.mem_ready) : !bus.mem_ready;

  always_comb begin
    bus.freeze_pc     = 1'b0;
    bus.freeze_if_id  = 1'b0;
    bus.bubble_id_exe = 1'b0;
    bus.flush_if_id   = 1'b0;
    bus.flush_id_exe  = 1'b0;
    if (freeze_all) begin
      bus.freeze_pc    = 1'b1;
      bus.freeze_if_id = 1'b1;
    end else if (bus.branch_taken) begin
      bus.flush_if_id  = 1'b1;
      bus.flush_id_exe = 1'b1;
    end else if (hazard) begin
      bus.freeze_pc     = 1'b1;
      bus.freeze_if_id  = 1'b1;
      bus.bubble_id_exe = 1'b1;
    end
  end

  // Watchdog count holds at its limit so it cannot wrap during a hung access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HZ_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        HZ_RUN: begin
          wait_cnt_q <= '0;
          if (bus.mem_req && !bus.mem_ready) begin
            state_q <= HZ_MEM_WAIT;
          end
        end
        HZ_MEM_WAIT: begin
          if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
          if (!bus.mem_ready && (wait_cnt_q == WAIT_MAX)) begin
            mem_timeout_q <= 1'b1;
          end
          if (bus.mem_ready) begin
            state_q <= HZ_RUN;
          end
        end
        default: state_q <= HZ_RUN;
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (freeze_all || hazard),
    .count_o (bus.stall_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (bus.bubble_id_exe),
    .count_o (bus.bubble_count)
  );

  assign bus.hazard      = hazard;
  assign bus.freeze_all  = freeze_all;
  assign bus.mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed vector table plus multi-cycle stall/timeout/saturation sequences
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hazard_stall_ctrl_if #(.REG_ADDR_W(4), .CNT_W(4)) bus ();

  hazard_stall_ctrl #(.REG_ADDR_W(4), .CNT_W(4), .MEM_TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       fwd;
    logic [3:0] s1;
    logic       s1v;
    logic [3:0] s2;
    logic       s2v;
    logic [3:0] ed;
    logic       ewb;
    logic       emr;
    logic [3:0] md;
    logic       mwb;
    logic       br;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input logic fwd, input logic [3:0] s1, input logic s1v,
                              input logic [3:0] s2, input logic s2v, input logic [3:0] ed,
                              input logic ewb, input logic emr, input logic [3:0] md,
                              input logic mwb, input logic br, input logic [6:0] exp);
    vec_t v;
    v.fwd = fwd; v.s1 = s1; v.s1v = s1v; v.s2 = s2; v.s2v = s2v;
    v.ed = ed; v.ewb = ewb; v.emr = emr; v.md = md; v.mwb = mwb;
    v.br = br; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.en_forwarding = 1'b0;
    bus.src1 = '0; bus.src2 = '0; bus.src1_valid = 1'b0; bus.src2_valid = 1'b0;
    bus.EXE_dst = '0; bus.EXE_wb_en = 1'b0; bus.EXE_mem_r_en = 1'b0;
    bus.MEM_dst = '0; bus.MEM_wb_en = 1'b0;
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0; bus.branch_taken = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    bus.en_forwarding = v.fwd;
    bus.src1 = v.s1; bus.src1_valid = v.s1v;
    bus.src2 = v.s2; bus.src2_valid = v.s2v;
    bus.EXE_dst = v.ed; bus.EXE_wb_en = v.ewb; bus.EXE_mem_r_en = v.emr;
    bus.MEM_dst = v.md; bus.MEM_wb_en = v.mwb;
    bus.branch_taken = v.br;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  function automatic logic [6:0] outs();
    return {bus.hazard, bus.freeze_pc, bus.freeze_if_id, bus.bubble_id_exe,
            bus.flush_if_id, bus.flush_id_exe, bus.freeze_all};
  endfunction

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    clear_inputs();

    // outputs: {hazard, freeze_pc, freeze_if_id, bubble, flush_if_id, flush_id_exe, freeze_all}
    tbl[0]  = mk(0, 4'd3, 1, 4'd0, 0, 4'd3, 1, 0, 4'd0, 0, 0, 7'b1111000);
    tbl[1]  = mk(1, 4'd3, 1, 4'd0, 0, 4'd3, 1, 0, 4'd0, 0, 0, 7'b0000000);
    tbl[2]  = mk(1, 4'd1, 1, 4'd5, 1, 4'd5, 1, 0, 4'd0, 0, 0, 7'b0000000);
    tbl[3]  = mk(1, 4'd1, 1, 4'd5, 1, 4'd5, 1, 1, 4'd0, 0, 0, 7'b1111000);
    tbl[4]  = mk(0, 4'd1, 1, 4'd7, 1, 4'd2, 1, 0, 4'd7, 1, 0, 7'b1111000);
    tbl[5]  = mk(1, 4'd1, 1, 4'd7, 1, 4'd2, 1, 0, 4'd7, 1, 0, 7'b0000000);
    tbl[6]  = mk(0, 4'd3, 0, 4'd0, 0, 4'd3, 1, 0, 4'd0, 0, 0, 7'b0000000);
    tbl[7]  = mk(0, 4'd3, 1, 4'd0, 0, 4'd3, 0, 0, 4'd0, 0, 0, 7'b0000000);
    tbl[8]  = mk(0, 4'd0, 1, 4'd9, 0, 4'd0, 1, 0, 4'd0, 0, 0, 7'b1111000);
    tbl[9]  = mk(0, 4'd3, 1, 4'd0, 0, 4'd3, 1, 0, 4'd0, 0, 1, 7'b1000110);
    tbl[10] = mk(1, 4'd1, 1, 4'd5, 1, 4'd5, 1, 1, 4'd0, 0, 1, 7'b1000110);
    tbl[11] = mk(1, 4'd1, 1, 4'd5, 1, 4'd5, 0, 1, 4'd0, 0, 0, 7'b0000000);

    // Reset state
    @(negedge clk);
    do_reset();
    chk("rst_mem_timeout", 32'(bus.mem_timeout), 32'd0);
    chk("rst_stall_count", 32'(bus.stall_count), 32'd0);
    chk("rst_bubble_count", 32'(bus.bubble_count), 32'd0);
    chk("rst_freeze_all", 32'(bus.freeze_all), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(HZ_RUN));

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i]);
      #1;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
      tick();
    end

    // No-forwarding hazard: one bubble for one cycle
    do_reset();
    apply(tbl[0]);
    tick();
    clear_inputs();
    #1;
    chk("nofwd_bubble_count", 32'(bus.bubble_count), 32'd1);
    chk("nofwd_stall_count", 32'(bus.stall_count), 32'd1);

    // Load-use with forwarding: one bubble, then load moves to MEM
    apply(tbl[3]);
    #1;
    chk("lu_cycle1_bubble", 32'(bus.bubble_id_exe), 32'd1);
    tick();
    bus.EXE_wb_en = 1'b0; bus.EXE_mem_r_en = 1'b0; bus.EXE_dst = 4'd0;
    bus.MEM_dst = 4'd5; bus.MEM_wb_en = 1'b1;
    #1;
    chk("lu_cycle2_hazard", 32'(bus.hazard), 32'd0);
    tick();
    chk("lu_bubble_count", 32'(bus.bubble_count), 32'd2);

    // SRAM wait: 4 frozen cycles, branch held off until unfrozen
    do_reset();
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    #1;
    chk("mw_c1_freeze", 32'(bus.freeze_all), 32'd1);
    chk("mw_c1_state", 32'(dut.state_q), 32'(HZ_RUN));
    tick();
    chk("mw_c2_freeze", 32'(bus.freeze_all), 32'd1);
    chk("mw_c2_state", 32'(dut.state_q), 32'(HZ_MEM_WAIT));
    tick();
    bus.branch_taken = 1'b1;
    #1;
    chk("mw_c3_freeze_pc", 32'(bus.freeze_pc), 32'd1);
    chk("mw_c3_flush", 32'({bus.flush_if_id, bus.flush_id_exe}), 32'd0);
    tick();
    chk("mw_c4_state", 32'(dut.state_q), 32'(HZ_MEM_WAIT));
    chk("mw_c4_flush", 32'({bus.flush_if_id, bus.flush_id_exe}), 32'd0);
    tick();
    bus.mem_ready = 1'b1;
    #1;
    chk("mw_c5_freeze", 32'(bus.freeze_all), 32'd0);
    chk("mw_c5_flush", 32'({bus.flush_if_id, bus.flush_id_exe}), 32'd3);
    tick();
    clear_inputs();
    #1;
    chk("mw_done_state", 32'(dut.state_q), 32'(HZ_RUN));
    chk("mw_stall_count", 32'(bus.stall_count), 32'd4);
    chk("mw_bubble_count", 32'(bus.bubble_count), 32'd0);

    // Watchdog at MEM_TIMEOUT=8
    do_reset();
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("wd_before", 32'(bus.mem_timeout), 32'd0);
    tick();
    chk("wd_raised", 32'(bus.mem_timeout), 32'd1);
    bus.mem_ready = 1'b1;
    tick();
    clear_inputs();
    tick();
    chk("wd_sticky", 32'(bus.mem_timeout), 32'd1);
    chk("wd_state_run", 32'(dut.state_q), 32'(HZ_RUN));

    // Saturation at CNT_W=4
    do_reset();
    apply(tbl[0]);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_bubble_count", 32'(bus.bubble_count), 32'd15);
    chk("sat_stall_count", 32'(bus.stall_count), 32'd15);

    // Reset in the middle of a hung wait
    clear_inputs();
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("rmw_timeout_set", 32'(bus.mem_timeout), 32'd1);
    rst = 1'b1;
    #1;
    chk("rmw_freeze_in_rst", 32'(bus.freeze_all), 32'd1);
    tick();
    rst = 1'b0;
    #1;
    chk("rmw_state", 32'(dut.state_q), 32'(HZ_RUN));
    chk("rmw_timeout_clr", 32'(bus.mem_timeout), 32'd0);
    chk("rmw_counts_clr", 32'({bus.stall_count, bus.bubble_count}), 32'd0);
    chk("rmw_rearm", 32'(bus.freeze_all), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
